// File: rtl/funnel_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : funnel_sched_if
// Description : Handshake bundle between funnel_sched and its surroundings.
//               Carries the per-lane data-available flags, the funnel's
//               select method, the funnel's out PipeOut (first/deq), the
//               downstream sink enq method and the debug grant index.
//               master : the scheduler side (drives ENAs, select_v, sink data)
//               slave  : the funnel/sink side (drives RDYs, avail, out__first)
// Revision    : 1.0  initial release
// ============================================================================
interface funnel_sched_if #(
    parameter int FUNNEL_WIDTH = 8,
    parameter int WIDTH        = 16
);
    logic [FUNNEL_WIDTH-1:0] avail;
    logic                    select__ENA;
    logic [31:0]             select_v;
    logic                    select__RDY;
    logic [WIDTH-1:0]        out__first;
    logic                    out__first__RDY;
    logic                    out__deq__ENA;
    logic                    out__deq__RDY;
    logic                    sink__enq__ENA;
    logic [WIDTH-1:0]        sink__enq_v;
    logic                    sink__enq__RDY;
    logic [4:0]              grant;

    modport master (
        input  avail, select__RDY, out__first, out__first__RDY,
               out__deq__RDY, sink__enq__RDY,
        output select__ENA, select_v, out__deq__ENA, sink__enq__ENA,
               sink__enq_v, grant
    );

    modport slave (
        output avail, select__RDY, out__first, out__first__RDY,
               out__deq__RDY, sink__enq__RDY,
        input  select__ENA, select_v, out__deq__ENA, sink__enq__ENA,
               sink__enq_v, grant
    );
endinterface
`default_nettype wire

// File: rtl/funnel_sched.sv
`default_nettype none
// ============================================================================
// Module      : funnel_sched
// Description : Round-robin scheduler for an N-to-1 SelectOut funnel. In IDLE
//               it picks the first lane with data at or after a rotating
//               pointer, programs the funnel's select with it, then in XFER
//               moves beats from the funnel's out port to the sink until the
//               burst limit is reached or the lane runs dry.
// Ports       : CLK  - clock, rising edge
//               RST  - synchronous reset, active-high
//               bus  - funnel_sched_if.master (avail, select, out, sink, grant)
// Config      : FUNNEL_SCHED_BURST_EN defined   -> up to MAX_BURST beats/grant
//               FUNNEL_SCHED_BURST_EN undefined -> exactly one beat per grant
// Revision    : 1.0  initial release
// ============================================================================
module funnel_sched #(
    parameter int FUNNEL_WIDTH = 8,
    parameter int WIDTH        = 16,
    parameter int MAX_BURST    = 4
) (
    input  logic           CLK,
    input  logic           RST,
    funnel_sched_if.master bus
);

    localparam int PTR_W = $clog2(FUNNEL_WIDTH);

    generate
        if (FUNNEL_WIDTH < 2 || FUNNEL_WIDTH > 32 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_param
            $error("funnel_sched: parameter out of range");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_grant;
    logic [PTR_W-1:0]   w_cand;
    logic               w_cand_vld;
    logic               w_sel_ena;
    logic               w_fire;
    logic               w_exit;
    logic               w_last_beat;
    logic               w_run;
    logic [WIDTH-1:0]   w_sink_data;

    // (base + off) mod FUNNEL_WIDTH for off < FUNNEL_WIDTH; works for
    // non-power-of-two lane counts.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(FUNNEL_WIDTH))
            sum = sum - 32'(FUNNEL_WIDTH);
        return PTR_W'(sum);
    endfunction

    // Scan from the farthest offset down to offset 0 so the lane nearest
    // at-or-after r_ptr is the last one written and therefore wins.
    always_comb begin
        w_cand_vld = 1'b0;
        w_cand     = '0;
        for (int k = FUNNEL_WIDTH - 1; k >= 0; k--) begin
            if (bus.avail[wrap_idx(r_ptr, k)]) begin
                w_cand_vld = 1'b1;
                w_cand     = wrap_idx(r_ptr, k);
            end
        end
    end

`ifdef FUNNEL_SCHED_BURST_EN
    logic [7:0] r_cnt;

    assign w_last_beat = (r_cnt == 8'(MAX_BURST - 1));

    // Wraps to 0 on the last beat so the stored count stays below MAX_BURST.
    always_ff @(posedge CLK) begin
        if (RST)
            r_cnt <= 8'd0;
        else if (w_sel_ena)
            r_cnt <= 8'd0;
        else if (w_fire)
            r_cnt <= w_last_beat ? 8'd0 : r_cnt + 8'd1;
    end
`else
    assign w_last_beat = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_sel_ena   = 1'b0;
        w_fire      = 1'b0;
        w_exit      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cand_vld && bus.select__RDY) begin
                    w_sel_ena   = 1'b1;
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                w_fire = bus.out__first__RDY & bus.out__deq__RDY & bus.sink__enq__RDY;
                // Release on burst completion, or when the lane has gone dry
                // and nothing is moving this cycle.
                w_exit = (w_fire & w_last_beat) | (~bus.avail[r_grant] & ~w_fire);
                if (w_exit)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_sel_ena)
                r_grant <= w_cand;
            if (w_exit)
                r_ptr <= wrap_idx(r_grant, 1);
        end
    end

    // The reset cycle must not fire any method, even if the state register
    // still says XFER from before the reset.
    assign w_run       = ~RST;
    assign w_sink_data = (r_state == XFER && w_run) ? bus.out__first : '0;

    assign bus.select__ENA    = w_sel_ena & w_run;
    assign bus.select_v       = (w_sel_ena & w_run) ? 32'(w_cand) : 32'd0;
    assign bus.out__deq__ENA  = w_fire & w_run;
    assign bus.sink__enq__ENA = w_fire & w_run;
    assign bus.sink__enq_v    = w_sink_data;
    assign bus.grant          = 5'(r_grant);

endmodule
`default_nettype wire

// File: tb/tb_funnel_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_funnel_sched
// Description : Self-checking bench for funnel_sched. A behavioural funnel
//               (per-lane word stores) feeds the scheduler; a transaction
//               level round-robin model predicts the grant order and the
//               beat stream, which the observed select/sink traffic must
//               match. Burst length follows FUNNEL_SCHED_BURST_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_funnel_sched;

    localparam int NL = 8;
    localparam int DW = 16;
`ifdef FUNNEL_SCHED_BURST_EN
    localparam int BURST = 4;
`else
    localparam int BURST = 1;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    funnel_sched_if #(.FUNNEL_WIDTH(NL), .WIDTH(DW)) bus ();

    funnel_sched #(
        .FUNNEL_WIDTH (NL),
        .WIDTH        (DW),
        .MAX_BURST    (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Funnel model: one word store per lane plus the lane the funnel has
    // been programmed to present on its out port.
    logic [DW-1:0] fmem [NL][64];
    int            fhead [NL];
    int            ftail [NL];
    int            fsel = 0;

    // Predicted traffic.
    int            exp_grant [$];
    int            exp_lane  [$];
    logic [DW-1:0] exp_data  [$];

    bit rnd       = 1'b0;
    bit sink_hold = 1'b0;

    // Outputs sampled in the middle of the last cycle.
    logic          s_sel, s_deq, s_sink;
    logic [31:0]   s_selv;
    logic [DW-1:0] s_sinkv;
    logic [4:0]    s_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit lanes_empty();
        for (int i = 0; i < NL; i++)
            if (ftail[i] != fhead[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic load_lane(input int l, input int n);
        if (ftail[l] == fhead[l]) begin
            fhead[l] = 0;
            ftail[l] = 0;
        end
        for (int i = 0; i < n; i++) begin
            fmem[l][ftail[l]] = DW'($urandom);
            ftail[l]++;
        end
    endtask

    // Round-robin at transaction level: starting from lane 0, each grant
    // takes min(BURST, words left) from the nearest non-empty lane, and the
    // next search starts just after it.
    task automatic build_expect();
        int len [NL];
        int pos [NL];
        int p, l, n;
        exp_grant.delete();
        exp_lane.delete();
        exp_data.delete();
        for (int i = 0; i < NL; i++) begin
            len[i] = ftail[i] - fhead[i];
            pos[i] = fhead[i];
        end
        p = 0;
        for (int g = 0; g < 1024; g++) begin
            l = -1;
            for (int k = 0; k < NL; k++)
                if (l < 0 && len[(p + k) % NL] > 0) l = (p + k) % NL;
            if (l < 0) break;
            exp_grant.push_back(l);
            n = (len[l] < BURST) ? len[l] : BURST;
            for (int b = 0; b < n; b++) begin
                exp_lane.push_back(l);
                exp_data.push_back(fmem[l][pos[l] + b]);
            end
            pos[l] += n;
            len[l] -= n;
            p = (l + 1) % NL;
        end
    endtask

    // One clock cycle: drive inputs from the model, sample at the falling
    // edge, then apply the fired methods to the model at the rising edge.
    task automatic tick();
        for (int i = 0; i < NL; i++) bus.avail[i] = (ftail[i] != fhead[i]);
        bus.out__first__RDY = (ftail[fsel] != fhead[fsel]);
        bus.out__first      = bus.out__first__RDY ? fmem[fsel][fhead[fsel]] : '0;
        bus.select__RDY     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.out__deq__RDY   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.sink__enq__RDY  = sink_hold ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        @(negedge CLK);
        s_sel   = bus.select__ENA;
        s_selv  = bus.select_v;
        s_deq   = bus.out__deq__ENA;
        s_sink  = bus.sink__enq__ENA;
        s_sinkv = bus.sink__enq_v;
        s_grant = bus.grant;
        chk("deq_eq_sink", s_deq, s_sink);
        if (s_sel)  chk("sel_needs_rdy", bus.select__RDY, 1);
        if (s_deq)  chk("deq_needs_rdy", bus.out__deq__RDY & bus.out__first__RDY, 1);
        if (s_sink) chk("sink_needs_rdy", bus.sink__enq__RDY, 1);
        @(posedge CLK);
        if (s_sel) begin
            if (exp_grant.size() == 0) chk("select_unexpected", s_selv, 32'hFFFF_FFFF);
            else                       chk("select_v", s_selv, exp_grant.pop_front());
            fsel = int'(s_selv[2:0]);
        end
        if (s_sink) begin
            if (exp_data.size() == 0) begin
                chk("beat_unexpected", s_sink, 0);
            end else begin
                chk("beat_data", s_sinkv, exp_data.pop_front());
                chk("beat_lane", s_grant, exp_lane.pop_front());
            end
            if (ftail[fsel] != fhead[fsel]) fhead[fsel]++;
        end
        #1;
    endtask

    task automatic reset_dut(input int n, input bit check);
        RST = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (check) begin
                chk("rst_sel_ena", s_sel, 0);
                chk("rst_sel_v", s_selv, 0);
                chk("rst_deq", s_deq, 0);
                chk("rst_sink", s_sink, 0);
                chk("rst_sink_v", s_sinkv, 0);
                if (i > 0) chk("rst_grant", s_grant, 0);
            end
        end
        RST = 1'b0;
    endtask

    task automatic drain(input string tag);
        int cyc = 0;
        while (!(lanes_empty() && exp_data.size() == 0) && cyc < 3000) begin
            tick();
            cyc++;
        end
        chk({tag, "_timeout"}, (cyc < 3000), 1);
        chk({tag, "_grants_left"}, exp_grant.size(), 0);
        tick();
        tick();
        chk({tag, "_idle_no_select"}, s_sel, 0);
    endtask

    task automatic run_beats(input int lane, input int target, input string tag);
        int got = 0;
        int cyc = 0;
        while (got < target && cyc < 500) begin
            tick();
            cyc++;
            if (s_sink && (lane < 0 || int'(s_grant) == lane)) got++;
        end
        chk(tag, got, target);
    endtask

    initial begin
        for (int i = 0; i < NL; i++) begin
            fhead[i] = 0;
            ftail[i] = 0;
        end
        bus.avail           = '0;
        bus.out__first      = '0;
        bus.out__first__RDY = 1'b0;
        bus.select__RDY     = 1'b0;
        bus.out__deq__RDY   = 1'b0;
        bus.sink__enq__RDY  = 1'b0;

        // Reset with every lane requesting, then a fair drain under random
        // backpressure: grants must rotate 0..7 repeatedly.
        for (int l = 0; l < NL; l++) load_lane(l, 12);
        reset_dut(3, 1'b1);
        build_expect();
        chk("first_grant_lane0", exp_grant[0], 0);
        rnd = 1'b1;
        drain("fair");

        // Single lane, all ready: select, BURST beats, select again.
        rnd = 1'b0;
        reset_dut(1, 1'b0);
        build_expect();
        tick();
        chk("empty_no_select", s_sel, 0);
        load_lane(2, 8);
        build_expect();
        for (int c = 0; c < 2 * (BURST + 1); c++) begin
            tick();
            chk("single_sel", s_sel, (c % (BURST + 1)) == 0);
            chk("single_beat", s_sink, (c % (BURST + 1)) != 0);
            if (c == 0) chk("single_sel_v", s_selv, 2);
        end
        drain("single");

        // Early release: lane 3 only holds two words.
        reset_dut(1, 1'b0);
        load_lane(0, 5);
        load_lane(3, 2);
        load_lane(5, 3);
        build_expect();
        drain("early");

        // Sink backpressure for five cycles in the middle of a burst.
        reset_dut(1, 1'b0);
        load_lane(5, 8);
        build_expect();
        run_beats(-1, 2, "bp_pre_beats");
        sink_hold = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_no_deq", s_deq, 0);
            chk("bp_no_sink", s_sink, 0);
            chk("bp_grant_kept", s_grant, 5);
        end
        sink_hold = 1'b0;
        drain("bp");

        // Reset in the middle of lane 6's burst: pointer returns to 0, so the
        // next grant is lane 2 rather than lane 6.
        reset_dut(1, 1'b0);
        load_lane(2, 6);
        load_lane(6, 8);
        build_expect();
        run_beats(6, (BURST > 1) ? 2 : 1, "midrst_pre_beats");
        reset_dut(1, 1'b0);
        chk("midrst_sel_ena", s_sel, 0);
        chk("midrst_deq", s_deq, 0);
        chk("midrst_sink", s_sink, 0);
        build_expect();
        tick();
        chk("midrst_reselect", s_sel, 1);
        chk("midrst_reselect_v", s_selv, 2);
        drain("midrst");

        // Random lane occupancy with random handshake stalls.
        for (int it = 0; it < 4; it++) begin
            rnd = 1'b0;
            reset_dut(1, 1'b0);
            for (int l = 0; l < NL; l++) load_lane(l, $urandom_range(0, 10));
            build_expect();
            rnd = 1'b1;
            drain("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
